// File: rtl/scan_decoder_if.sv
// Bus bundle for scan_decoder: control inputs and registered select outputs.
// There is no valid/ready handshake on this bus. Every input is sampled on each
// rising clk edge. Every output is a register that stays stable for the whole
// cycle after that edge. tick and wrap are single-cycle strobes that line up
// with the idx/out update they describe.
interface scan_decoder_if #(
  parameter int SEL_W = 2
);
  localparam int N = 2**SEL_W;

  logic             en;
  logic             mode;
  logic             load;
  logic [SEL_W-1:0] in;
  logic [N-1:0]     out;
  logic [SEL_W-1:0] idx;
  logic             tick;
  logic             wrap;

  // The stimulus side drives the controls and observes the select lines.
  modport master (
    output en, mode, load, in,
    input  out, idx, tick, wrap
  );

  // The decoder side receives the controls and drives the select lines.
  modport slave (
    input  en, mode, load, in,
    output out, idx, tick, wrap
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with two modes. In direct mode it
// decodes an index that was loaded. In scan mode a prescaler advances the index
// round-robin. Output polarity is selectable. tick and wrap mark each scan step.
// The SEL_W of the connected interface must equal the SEL_W of this module.
module scan_decoder #(
  parameter int SEL_W      = 2,
  parameter int DIV        = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  scan_decoder_if.slave   bus
);
  localparam int N  = 2**SEL_W;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]    PRE_MAX  = PW'(DIV - 1);
  localparam logic [SEL_W-1:0] IDX_MAX  = SEL_W'(N - 1);
  localparam logic [N-1:0]     INACTIVE = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

  logic [SEL_W-1:0] idx_q, idx_next;
  logic [PW-1:0]    pre_q, pre_next;
  logic [N-1:0]     out_q, out_next;
  logic             tick_q, tick_next;
  logic             wrap_q, wrap_next;

  // Put one line in its active state and every other line in the inactive state.
  function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] sel);
    logic [N-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  // Choose the next index and prescaler value. Priority order is load, enable,
  // direct mode, then scan. out is decoded from idx_next so out and idx agree.
  always_comb begin
    idx_next  = idx_q;
    pre_next  = pre_q;
    tick_next = 1'b0;
    wrap_next = 1'b0;
    if (bus.load) begin
      idx_next = bus.in;
      pre_next = '0;
    end else if (bus.en) begin
      if (!bus.mode) begin
        pre_next = '0;
      end else if (pre_q == PRE_MAX) begin
        pre_next  = '0;
        idx_next  = idx_q + SEL_W'(1);
        tick_next = 1'b1;
        wrap_next = (idx_q == IDX_MAX);
      end else begin
        pre_next = pre_q + PW'(1);
      end
    end
    out_next = bus.en ? decode(idx_next) : INACTIVE;
  end

  // Register all state and outputs. Reset is asynchronous and active low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      pre_q  <= '0;
      out_q  <= INACTIVE;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_next;
      pre_q  <= pre_next;
      out_q  <= out_next;
      tick_q <= tick_next;
      wrap_q <= wrap_next;
    end
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;
endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised, registered binary-to-one-hot decoder with a direct-select mode and an auto-scan mode. In direct mode it decodes a loaded index. In scan mode it steps the selected output through every line in turn at a programmable rate, for multiplexed display digit selection and round-robin enables. It generalises the 2-to-4 decoder to 2**SEL_W lines and adds enable, output polarity, prescaled scanning and step/wrap strobes.

## Interface
- SEL_W, default 2: index width; output width is N = 2**SEL_W; legal range 1..5.
- DIV, default 4: enabled clock cycles per scan step; legal range 1..65535.
- ACTIVE_LOW, default 0: 0 means the selected line is 1 and others are 0; 1 means the selected line is 0 and others are 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  enable; 0 forces all outputs inactive and freezes stepping.
- mode  in  1  0 = direct, 1 = scan.
- load  in  1  loads `in` into the index register on the next edge.
- in  in  SEL_W  index to load.
- out  out  N  one-hot (or one-cold) select lines, registered.
- idx  out  SEL_W  current index, registered.
- tick  out  1  one-cycle strobe: the index advanced by a scan step.
- wrap  out  1  one-cycle strobe: the scan step took the index from N-1 to 0.

## Operation
- State: idx register (SEL_W bits), prescaler pre (ceil(log2(DIV)) bits, minimum 1), and registered out/tick/wrap.
- Inactive output value: all 0 when ACTIVE_LOW=0, all 1 when ACTIVE_LOW=1.
- On reset: idx=0, pre=0, out=inactive, tick=0, wrap=0.
- Each edge computes idx_next and writes idx<=idx_next.
  - out<=en ? decode(idx_next) : inactive, so out always matches idx on the same cycle.
  - tick and wrap are 0 unless a step occurs.
- Priority per edge, highest first:
  1. load=1 sets idx_next=in and pre=0. No tick or wrap. Load is honoured in either mode and regardless of en.
  2. en=0 holds idx and pre.
  3. mode=0 (direct) holds idx and forces pre=0.
  4. mode=1 (scan) with pre==DIV-1 sets pre=0 and idx_next=(idx+1) mod N, with tick=1. wrap=1 if idx==N-1.
  5. mode=1 otherwise sets pre=pre+1 and holds idx.
- Index arithmetic is modulo N with natural SEL_W-bit rollover. The bench never drives `in` with X.
- Switching mode 0→1: the first step occurs DIV enabled cycles later, because pre is already 0.
- Switching mode 1→0: pre clears on that edge and idx holds.
- DIV=1: a step occurs on every enabled scan cycle; pre stays 0.
- en deasserted mid-count: the partial prescaler count is retained, and scanning resumes from it when en returns.
- Asynchronous reset asserted mid-operation: all state and outputs go to reset values immediately, without waiting for clk. Deassertion is synchronised externally.

## Timing
- Load latency is 1 cycle: load sampled at edge k gives idx and out valid after edge k.
- Scan period: exactly DIV clk cycles per index while en=1, mode=1, load=0.
- tick/wrap assert for exactly one cycle, after the same edge that updates idx/out.
- en to out latency is 1 cycle in both directions.
- No combinational path from any input to any output.

## Test plan
- Reset (SEL_W=2, DIV=4, ACTIVE_LOW=0): hold rst_n=0 with clk running → out=4'b0000, idx=0, tick=0, wrap=0. Then assert rst_n=0 asynchronously between edges mid-scan → outputs return to reset values before the next edge.
- Direct mode: en=1, mode=0, load pulses with in=0,1,2,3 → out=0001, 0010, 0100, 1000, each one cycle after its load edge, and held without load.
- Scan from idx=0: en=1, mode=1 for 16 cycles.
  - Required: idx steps 1, 2, 3, 0 on the 4th, 8th, 12th and 16th edges, with out following 0010, 0100, 1000, 0001.
  - Required: tick high on those four cycles only, and wrap high only on the 16th.
- Enable drop: after 2 counts at idx=1, drive en=0 for 5 cycles → out=0000 and idx=1 frozen. Restore en=1 → idx becomes 2 after 2 more edges.
- Load vs. step collision: in scan at pre=3, assert load with in=2 → idx=2, tick=0, and the next step occurs 4 cycles later.
- Parameter sweep: instance with SEL_W=3, DIV=1, ACTIVE_LOW=1 → reset out=8'hFF; scan walks one zero bit through all 8 positions, one per cycle, with wrap every 8th cycle.
